dmem_access_arbiter: RTL and testbench
======================================

Name: dmem_access_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the pipeline memory-access stage, port 1 is the loader/debug port that preloads and inspects memory.
- Sits between the requesters and data_memory, and drives mem_read, mem_write, address and write_data.
- Serialises accesses with round-robin arbitration, sequences each access through a small state machine and returns registered acknowledges and read data.
- Produces a stall for the pipeline while its access is pending.

Parameters:
- READ_LATENCY, 0: cycles from the mem_read strobe until mem_rdata is valid. 0 means combinational read; allowed range is 0..7.
- CHECK_ALIGN, 1: when 1, an access whose addr[2:0] != 0 is rejected with an error and does not touch memory.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req  in  1  pipeline request.
- p0_we  in  1  1 = store, 0 = load.
- p0_addr  in  64  byte address.
- p0_wdata  in  64  store data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_err  out  1  valid with p0_ack; misaligned access.
- p0_rdata  out  64  load data, valid with p0_ack; held until the next p0 load ack.
- p0_stall  out  1  p0_req & ~p0_ack (combinational).
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same widths and meanings for the loader port.
- mem_read  out  1  read strobe to data_memory.
- mem_write  out  1  write strobe to data_memory.
- mem_addr  out  64  latched address.
- mem_wdata  out  64  latched store data.
- mem_rdata  in  64  read data from data_memory.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - All ack/err outputs 0; p*_rdata=0; mem_read=mem_write=0; mem_addr=mem_wdata=0.
  - Latency counter=0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On grant: latch sel, we, addr, wdata; update last_grant; go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (exactly one cycle):
  - mem_addr/mem_wdata drive the latched values.
  - mem_write=we, mem_read=~we. Strobes are decoded from state and the latched values only.
  - Misaligned access with CHECK_ALIGN=1: both strobes stay 0, err_pending is set, go to RESP.
  - Write: go to RESP.
  - Read with READ_LATENCY=0: capture mem_rdata at the end of ACCESS, go to RESP.
  - Read with READ_LATENCY>0: load counter=READ_LATENCY, go to WAIT.
- WAIT:
  - Strobes are 0; mem_addr is held.
  - Counter decrements each cycle.
  - When counter==1, capture mem_rdata at the end of that cycle and go to RESP.
- RESP (one cycle):
  - The selected port's ack=1; err=err_pending.
  - The selected port's rdata register updates only for a successful load.
  - The other port's ack stays 0.
  - Next state is IDLE. No arbitration occurs in RESP.
- Latency, with req sampled at edge 0:
  - Store or error: ack in cycle 2.
  - Load: ack in cycle 2+READ_LATENCY.
  - Minimum issue interval is 3 cycles.
- Requesters hold req and operands until ack. Operands are latched at grant; changes after grant are ignored.
- req dropped after grant: the access still completes and ack still pulses.
- req dropped before grant: nothing happens.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1.
- Reset mid-operation:
  - Reset at any edge forces IDLE and clears all outputs on that edge.
  - A write whose ACCESS cycle coincides with the reset edge still commits in data_memory.
  - No ack is produced for an aborted access.
- There are no combinational paths from mem_rdata to outputs. The only combinational outputs are p*_stall and busy.

Test Plan:
- Reset, then p0 store addr=0x10 wdata=100 -> mem_write high in cycle 1 only, mem_addr=0x10; p0_ack in cycle 2; p0_stall high in cycles 0-1; then a p0 load of 0x10 returns p0_rdata=100 with ack.
- p0 and p1 both request at edge 0 (p0 load 0x08, p1 store 0x20=7) -> p0 granted first; p1 ACCESS begins 3 cycles later; continuous dual requests alternate grants over 6 accesses.
- READ_LATENCY=3, p1 load 0x18 preloaded with 0xDEADBEEF -> mem_read pulses one cycle; p1_ack in cycle 5 with p1_rdata=0xDEADBEEF; p0_ack stays 0.
- p0 store addr=0x0C -> no mem_write in any cycle; p0_ack=1 and p0_err=1 in cycle 2; memory unchanged; with CHECK_ALIGN=0 the write occurs.
- Reset asserted during WAIT of a p0 load -> IDLE next cycle, no p0_ack, p0_rdata=0, busy=0; the next request is served normally.
- p1 changes addr after grant and drops req in ACCESS -> access uses the originally latched address; p1_ack still pulses once.

Source files
------------

// File: rtl/dmem_access_arbiter.sv
// Data-memory port arbiter: round-robin between the pipeline (port 0) and the
// loader/debug port (port 1), one access in flight, registered responses.

module dmem_arb_resp_lane (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        done,
   input  logic        done_err,
   input  logic        capture,
   input  logic [63:0] rdata_in,
   output logic        ack,
   output logic        err,
   output logic [63:0] rdata,
   output logic        stall
);
   always_ff @(posedge clk) begin
      if (reset) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else begin
         ack <= done;
         err <= done & done_err;
         if (capture) rdata <= rdata_in;
      end
   end

   assign stall = req & ~ack;
endmodule

module dmem_access_arbiter #(
   parameter int READ_LATENCY = 0,
   parameter bit CHECK_ALIGN  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [63:0] p0_addr,
   input  logic [63:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [63:0] p0_rdata,
   output logic        p0_stall,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [63:0] p1_addr,
   input  logic [63:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [63:0] p1_rdata,
   output logic        p1_stall,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   output logic        busy
);
   localparam int         NUM_PORTS = 2;
   localparam logic [2:0] RL        = 3'(READ_LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } mem_req_t;

   state_t   state, state_nxt;
   logic     last_grant, sel_q, we_q, err_q;
   logic [2:0] cnt;

   logic [NUM_PORTS-1:0]      req_v;
   mem_req_t [NUM_PORTS-1:0]  req_in;
   logic [NUM_PORTS-1:0]      lane_ack, lane_err, lane_stall;
   logic [NUM_PORTS-1:0][63:0] lane_rdata;

   logic     gnt_fire, gnt_sel, gnt_err;
   mem_req_t gnt;
   logic     capture, resp_fire;

   assign req_v     = {p1_req, p0_req};
   assign req_in[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
   assign req_in[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

   // A tie goes to the port that did not win last; a lone requester always wins.
   always_comb begin
      gnt_sel  = (&req_v) ? ~last_grant : req_v[1];
      gnt      = req_in[gnt_sel];
      gnt_err  = CHECK_ALIGN && (gnt.addr[2:0] != 3'b000);
      gnt_fire = (state == IDLE) && (|req_v);
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE:    if (gnt_fire) state_nxt = ACCESS;
         ACCESS: begin
            if (err_q || we_q || READ_LATENCY == 0) begin
               state_nxt = RESP;
               capture   = ~err_q & ~we_q;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 3'd1) begin
               state_nxt = RESP;
               capture   = 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign resp_fire = (state_nxt == RESP);

   // Strobes are registered off the grant so they are high exactly in ACCESS.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         sel_q      <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         cnt        <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state     <= state_nxt;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         if (gnt_fire) begin
            sel_q      <= gnt_sel;
            last_grant <= gnt_sel;
            we_q       <= gnt.we;
            err_q      <= gnt_err;
            mem_addr   <= gnt.addr;
            mem_wdata  <= gnt.wdata;
            mem_write  <= gnt.we & ~gnt_err;
            mem_read   <= ~gnt.we & ~gnt_err;
         end
         if (state == ACCESS && state_nxt == WAIT) cnt <= RL;
         else if (state == WAIT)                   cnt <= cnt - 3'd1;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
      dmem_arb_resp_lane u_lane (
         .clk      (clk),
         .reset    (reset),
         .req      (req_v[i]),
         .done     (resp_fire & (sel_q == 1'(i))),
         .done_err (err_q),
         .capture  (capture & (sel_q == 1'(i))),
         .rdata_in (mem_rdata),
         .ack      (lane_ack[i]),
         .err      (lane_err[i]),
         .rdata    (lane_rdata[i]),
         .stall    (lane_stall[i])
      );
   end

   assign p0_ack   = lane_ack[0];
   assign p0_err   = lane_err[0];
   assign p0_rdata = lane_rdata[0];
   assign p0_stall = lane_stall[0];
   assign p1_ack   = lane_ack[1];
   assign p1_err   = lane_err[1];
   assign p1_rdata = lane_rdata[1];
   assign p1_stall = lane_stall[1];
   assign busy     = (state != IDLE);
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: two instances (combinational read with alignment
// check, 3-cycle read without it) against a transaction-level model.

module tb_dmem_access_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        req   [2][2];
   logic        we    [2][2];
   logic [63:0] addr  [2][2];
   logic [63:0] wdata [2][2];
   logic        ack   [2][2];
   logic        err   [2][2];
   logic [63:0] rdata [2][2];
   logic        stall [2][2];
   logic        mem_read  [2];
   logic        mem_write [2];
   logic        busy      [2];
   logic [63:0] mem_addr  [2];
   logic [63:0] mem_wdata [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 0 : 3;
      logic [63:0] mem     [64] = '{default: '0};
      logic [63:0] rd_pipe [4]  = '{default: '0};
      logic        rd_vld  [4]  = '{default: 1'b0};
      logic [63:0] rdata_m;

      dmem_access_arbiter #(.READ_LATENCY(LAT), .CHECK_ALIGN(g == 0)) u_dut (
         .clk(clk), .reset(reset),
         .p0_req(req[g][0]), .p0_we(we[g][0]), .p0_addr(addr[g][0]), .p0_wdata(wdata[g][0]),
         .p0_ack(ack[g][0]), .p0_err(err[g][0]), .p0_rdata(rdata[g][0]), .p0_stall(stall[g][0]),
         .p1_req(req[g][1]), .p1_we(we[g][1]), .p1_addr(addr[g][1]), .p1_wdata(wdata[g][1]),
         .p1_ack(ack[g][1]), .p1_err(err[g][1]), .p1_rdata(rdata[g][1]), .p1_stall(stall[g][1]),
         .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(rdata_m), .busy(busy[g])
      );

      // Read data is only valid LAT cycles after the strobe; garbage otherwise.
      always @(posedge clk) begin
         if (mem_write[g]) mem[mem_addr[g][5:0]] <= mem_wdata[g];
         rd_vld[0]  <= mem_read[g];
         rd_pipe[0] <= mem[mem_addr[g][5:0]];
         for (int i = 1; i < 4; i++) begin
            rd_vld[i]  <= rd_vld[i-1];
            rd_pipe[i] <= rd_pipe[i-1];
         end
      end

      if (LAT == 0) begin : g_comb
         always_comb rdata_m = mem[mem_addr[g][5:0]];
      end else begin : g_lat
         always_comb rdata_m = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   int checks = 0;
   int errors = 0;

   logic [63:0] ref_mem [2][64];
   logic [63:0] exp_rd  [2][2];
   bit          last_g  [2];

   function automatic int rlat(int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit calign(int d);
      return d == 0;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         last_g[d] = 1'b1;
         exp_rd[d][0] = '0;
         exp_rd[d][1] = '0;
      end
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
         end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One request from each selected port, presented together; each port drops req
   // when it sees its ack. drop: the first-granted port drops req and scrambles its
   // operands right after the grant.
   task automatic run_pair(int d, bit r0, bit w0, logic [63:0] a0, logic [63:0] v0,
                           bit r1, bit w1, logic [63:0] a1, logic [63:0] v1, bit drop);
      bit          rq [2];
      bit          wq [2];
      logic [63:0] aq [2];
      logic [63:0] vq [2];
      bit          e  [2];
      int          order [2];
      int          ack_at [2];
      int          acc_at [2];
      int          n_ops, t, lat, last, n_wr, n_rd, exp_wr, exp_rdn;
      rq = '{r0, r1}; wq = '{w0, w1}; aq = '{a0, a1}; vq = '{v0, v1};
      e = '{1'b0, 1'b0}; order = '{0, 0}; ack_at = '{0, 0}; acc_at = '{0, 0};
      n_ops = 0;
      if (r0 && r1) begin
         order[0] = last_g[d] ? 0 : 1;
         order[1] = 1 - order[0];
         n_ops = 2;
      end else if (r0 || r1) begin
         order[0] = r1 ? 1 : 0;
         n_ops = 1;
      end
      t = 0; last = 0; exp_wr = 0; exp_rdn = 0;
      for (int k = 0; k < n_ops; k++) begin
         int p;
         p = order[k];
         e[p] = calign(d) && (aq[p][2:0] != 3'b000);
         lat = (e[p] || wq[p]) ? 2 : 2 + rlat(d);
         acc_at[p] = t + 1;
         ack_at[p] = t + lat;
         if (!e[p]) begin
            if (wq[p]) begin
               ref_mem[d][aq[p][5:0]] = vq[p];
               exp_wr++;
            end else begin
               exp_rd[d][p] = ref_mem[d][aq[p][5:0]];
               exp_rdn++;
            end
         end
         last_g[d] = (p == 1);
         last = ack_at[p];
         t = ack_at[p] + 1;
      end

      @(negedge clk);
      req[d][0] = r0; we[d][0] = w0; addr[d][0] = a0; wdata[d][0] = v0;
      req[d][1] = r1; we[d][1] = w1; addr[d][1] = a1; wdata[d][1] = v1;
      n_wr = 0; n_rd = 0;
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            bit xa;
            xa = rq[p] && (n == ack_at[p]);
            chk($sformatf("d%0d_p%0d_ack_c%0d", d, p, n), ack[d][p], xa);
            chk($sformatf("d%0d_p%0d_stall_c%0d", d, p, n), stall[d][p], req[d][p] & ~xa);
            if (rq[p] && n == acc_at[p])
               chk($sformatf("d%0d_p%0d_mem_addr", d, p), mem_addr[d], aq[p]);
            if (xa) begin
               chk($sformatf("d%0d_p%0d_err", d, p), err[d][p], e[p]);
               chk($sformatf("d%0d_p%0d_rdata", d, p), rdata[d][p], exp_rd[d][p]);
               req[d][p] = 1'b0;
            end
         end
         n_wr += int'(mem_write[d]);
         n_rd += int'(mem_read[d]);
         if (drop && n == 1 && n_ops > 0) begin
            req[d][order[0]]   = 1'b0;
            addr[d][order[0]]  = 64'($urandom_range(0, 63));
            wdata[d][order[0]] = 64'($urandom);
         end
      end
      chk($sformatf("d%0d_write_strobes", d), 64'(n_wr), 64'(exp_wr));
      chk($sformatf("d%0d_read_strobes", d), 64'(n_rd), 64'(exp_rdn));
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      a = 64'(8 * $urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(1, 7));
      return a;
   endfunction

   initial begin
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;
      reset = 1'b1;
      clear_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", busy[d], 1'b0);
         chk("rst_mem_read", mem_read[d], 1'b0);
         chk("rst_mem_write", mem_write[d], 1'b0);
         chk("rst_mem_addr", mem_addr[d], 64'h0);
         chk("rst_mem_wdata", mem_wdata[d], 64'h0);
         for (int p = 0; p < 2; p++) begin
            chk("rst_ack", ack[d][p], 1'b0);
            chk("rst_err", err[d][p], 1'b0);
            chk("rst_rdata", rdata[d][p], 64'h0);
            chk("rst_stall", stall[d][p], 1'b0);
         end
      end
      reset = 1'b0;

      // store then load back on the pipeline port
      run_pair(0, 1, 1, 64'h10, 64'd100, 0, 0, 0, 0, 0);
      run_pair(0, 1, 0, 64'h10, 64'd0, 0, 0, 0, 0, 0);

      // contention from reset: port 0 first, then alternation
      do_reset();
      run_pair(0, 1, 0, 64'h08, 64'd0, 1, 1, 64'h20, 64'd7, 0);
      for (int i = 0; i < 3; i++)
         run_pair(0, 1, 1, 64'(8 * i), 64'(i + 50), 1, 0, 64'h20, 64'd0, 0);

      // long read latency on the loader port
      run_pair(1, 0, 0, 0, 0, 1, 1, 64'h18, 64'hDEAD_BEEF, 0);
      run_pair(1, 0, 0, 0, 0, 1, 0, 64'h18, 64'd0, 0);

      // misaligned: rejected with alignment check, performed without it
      run_pair(0, 1, 1, 64'h0C, 64'h55, 0, 0, 0, 0, 0);
      run_pair(0, 1, 0, 64'h08, 64'd0, 0, 0, 0, 0, 0);
      run_pair(1, 1, 1, 64'h0C, 64'h55, 0, 0, 0, 0, 0);
      run_pair(1, 1, 0, 64'h0C, 64'd0, 0, 0, 0, 0, 0);

      // operands change and req drops after grant
      run_pair(0, 0, 0, 0, 0, 1, 1, 64'h30, 64'h1234, 1);
      run_pair(0, 0, 0, 0, 0, 1, 0, 64'h30, 64'd0, 0);

      // reset while a load sits in WAIT
      run_pair(1, 1, 0, 64'h18, 64'd0, 0, 0, 0, 0, 0);
      @(negedge clk);
      req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 64'h18;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      req[1][0] = 1'b0;
      @(negedge clk);
      chk("wait_rst_busy", busy[1], 1'b0);
      chk("wait_rst_ack", ack[1][0], 1'b0);
      chk("wait_rst_rdata", rdata[1][0], 64'h0);
      reset = 1'b0;
      model_reset();
      repeat (5) begin
         @(negedge clk);
         chk("wait_rst_no_ack", ack[1][0], 1'b0);
      end
      run_pair(1, 1, 0, 64'h18, 64'd0, 0, 0, 0, 0, 0);

      // randomized traffic on both configurations
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 40; i++)
            run_pair(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
                     64'({$urandom, $urandom}),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
                     64'({$urandom, $urandom}),
                     $urandom_range(0, 3) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
